serializer: RTL

Parallel-to-serial transmitter for the SerDes link. It accepts 8-bit words over a valid/ready handshake and drives them LSB-first onto a single serial line. The line runs in a free-running 9-cycle frame, 8 data slots followed by 1 gap slot, so it stays slot-aligned with the link's deserializer when both blocks leave reset on the same edge. One word can be held in a buffer while the current word shifts out, which gives sustained throughput of one word per 9 cycles.

---
 rtl/serializer.sv | 57 +++++
 1 files changed

// File: rtl/serializer.sv
// serializer: LSB-first parallel-to-serial transmitter with a free-running
// WIDTH+1 slot frame and a one-deep holding buffer.
module serializer #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] IDLE_WORD = '0,
    parameter logic             GAP_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             data_out,
    output logic             frame_start,
    output logic             frame_live,
    output logic             underrun
);
    localparam int SW = $clog2(WIDTH + 1);
    localparam logic [SW-1:0] LAST = SW'(WIDTH);
    logic [SW-1:0]    slot, slot_n;
    logic [WIDTH-1:0] sh, sh_n, hold_d;
    logic             hold_v, live, live_n, gap, accept, hold_wr, out_n;
    assign gap         = slot == LAST;
    assign data_ready  = !hold_v || gap;
    assign accept      = data_valid && data_ready;
    assign hold_wr     = accept && (hold_v || !gap);
    assign frame_start = slot == '0;
    assign frame_live  = live && !gap;
    assign underrun    = frame_start && !live;
    // data_out is registered, so it is fed from the next-cycle slot and shift state
    always_comb begin
        slot_n = gap ? '0 : slot + 1'b1;
        sh_n   = !gap ? sh >> 1 : hold_v ? hold_d : accept ? data_in : IDLE_WORD;
        live_n = gap ? (hold_v || accept) : live;
        out_n  = slot_n == LAST ? GAP_LEVEL : sh_n[0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            slot     <= '0;
            sh       <= IDLE_WORD;
            live     <= 1'b0;
            hold_v   <= 1'b0;
            data_out <= IDLE_WORD[0];
        end else begin
            slot     <= slot_n;
            sh       <= sh_n;
            live     <= live_n;
            data_out <= out_n;
            if (hold_wr) begin
                hold_v <= 1'b1;
                hold_d <= data_in;
            end else if (gap) begin
                hold_v <= 1'b0;
            end
        end
    end
endmodule
